// File: rtl/booth_r4_mult.sv
// Radix-4 Booth sequential multiplier, signed or unsigned operands selected per request.
// Two multiplier bits retire per clock; Result is registered and held until the next product.
module booth_r4_mult #(
  parameter int N_BIT = 8
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Request,
  input  logic               Signed,
  input  logic [N_BIT-1:0]   op1,
  input  logic [N_BIT-1:0]   op2,
  output logic [2*N_BIT-1:0] Result,
  output logic               Done,
  output logic               Busy
);

  localparam int M    = 2 * ((N_BIT + 2) / 2);
  localparam int ITER = M / 2;
  localparam int SW   = $clog2(ITER + 1);
  localparam int AW   = 2 * M;
  localparam int PW   = M + 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [M-1:0]    r_mcand;
  logic [M-1:0]    r_mplier;
  logic            r_mprev;
  logic [AW-1:0]   r_acc;
  logic [SW-1:0]   r_step;

  logic            w_start;
  logic            w_last;
  logic [M-1:0]    w_op1_ext;
  logic [M-1:0]    w_op2_ext;
  logic [PW-1:0]   w_a;
  logic [PW-1:0]   w_pp;
  logic [AW-1:0]   w_pp_sh;
  logic [AW-1:0]   w_acc_next;

  // M >= N_BIT+1, so an unsigned operand is still a non-negative M-bit two's complement value
  assign w_op1_ext = {{(M-N_BIT){Signed & op1[N_BIT-1]}}, op1};
  assign w_op2_ext = {{(M-N_BIT){Signed & op2[N_BIT-1]}}, op2};

  assign w_start = (r_state != CALC) && Request;
  assign w_last  = (r_state == CALC) && (r_step == SW'(ITER - 1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (Request) w_state_next = CALC;
      CALC:       if (w_last)  w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_a  = {{2{r_mcand[M-1]}}, r_mcand};
    w_pp = '0;
    case ({r_mplier[1:0], r_mprev})
      3'b001, 3'b010: w_pp = w_a;
      3'b011:         w_pp = w_a << 1;
      3'b100:         w_pp = -(w_a << 1);
      3'b101, 3'b110: w_pp = -w_a;
      default:        w_pp = '0;
    endcase
    // Partial product is weighted by 4^step; the multiplier shifts right to expose each triplet
    w_pp_sh    = {{(AW-PW){w_pp[PW-1]}}, w_pp} << {r_step, 1'b0};
    w_acc_next = r_acc + w_pp_sh;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_mprev  <= 1'b0;
      r_acc    <= '0;
      r_step   <= '0;
      Result   <= '0;
      Done     <= 1'b0;
      Busy     <= 1'b0;
    end else if (w_start) begin
      r_mcand  <= w_op1_ext;
      r_mplier <= w_op2_ext;
      r_mprev  <= 1'b0;
      r_acc    <= '0;
      r_step   <= '0;
      Done     <= 1'b0;
      Busy     <= 1'b1;
    end else if (r_state == CALC) begin
      r_acc    <= w_acc_next;
      r_mplier <= {2'b00, r_mplier[M-1:2]};
      r_mprev  <= r_mplier[1];
      r_step   <= r_step + SW'(1);
      if (w_last) begin
        Result <= w_acc_next[2*N_BIT-1:0];
        Done   <= 1'b1;
        Busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench for booth_r4_mult: directed handshake cases at N_BIT=8,
// random back-to-back products at N_BIT=7 and 16 against an arithmetic reference.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        req8, sg8, done8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        req7, sg7, done7, busy7;
  logic [6:0]  a7, b7;
  logic [13:0] res7;
  logic        req16, sg16, done16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] res16;

  int total = 0;
  int bad   = 0;

  booth_r4_mult #(.N_BIT(8)) u_dut8 (
    .Clock(clk), .nReset(nrst), .Request(req8), .Signed(sg8), .op1(a8), .op2(b8),
    .Result(res8), .Done(done8), .Busy(busy8));

  booth_r4_mult #(.N_BIT(7)) u_dut7 (
    .Clock(clk), .nReset(nrst), .Request(req7), .Signed(sg7), .op1(a7), .op2(b7),
    .Result(res7), .Done(done7), .Busy(busy7));

  booth_r4_mult #(.N_BIT(16)) u_dut16 (
    .Clock(clk), .nReset(nrst), .Request(req16), .Signed(sg16), .op1(a16), .op2(b16),
    .Result(res16), .Done(done16), .Busy(busy16));

  // Reference: interpret operands as n-bit signed/unsigned integers, multiply, keep 2n bits
  function automatic longint refp(longint a, longint b, int n, bit sg);
    longint mask, half, sa, sb;
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    sa   = a & mask;
    sb   = b & mask;
    if (sg) begin
      sa = (sa ^ half) - half;
      sb = (sb ^ half) - half;
    end
    return (sa * sb) & ((longint'(1) << (2 * n)) - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on the 8-bit unit; operands are scrambled while it runs
  task automatic do8(input bit sg, input logic [7:0] a, input logic [7:0] b, output int cyc);
    @(negedge clk);
    req8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    @(negedge clk);
    req8 = 1'b0;
    cyc  = 0;
    while (busy8 && cyc < 20) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sg8 = 1'($urandom);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic b2b(input int n);
    int     issued = 0;
    int     checked = 0;
    int     cyc = 0;
    int     budget;
    longint q[$];
    longint a, b, r, e, mask;
    bit     s;
    logic   bz, dn;
    budget = 400 * ((n + 2) / 2 + 1) + 50;
    mask   = (longint'(1) << n) - 1;
    while (checked < 400 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (n == 7) begin bz = busy7;  dn = done7;  r = longint'(res7);  end
      else        begin bz = busy16; dn = done16; r = longint'(res16); end
      if (dn && !bz && q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("b2b%0d_op%0d", n, checked), 64'(r), 64'(e));
        checked++;
      end
      if (!bz) begin
        if (issued < 400) begin
          s = (issued >= 200);
          a = longint'($urandom) & mask;
          b = longint'($urandom) & mask;
          if (n == 7) begin req7 = 1'b1; sg7 = s; a7 = a[6:0]; b7 = b[6:0]; end
          else        begin req16 = 1'b1; sg16 = s; a16 = a[15:0]; b16 = b[15:0]; end
          q.push_back(refp(a, b, n, s));
          issued++;
        end else begin
          if (n == 7) req7 = 1'b0; else req16 = 1'b0;
        end
      end
    end
    req7 = 1'b0; req16 = 1'b0;
    chk($sformatf("b2b%0d_count", n), 64'(checked), 64'd400);
  endtask

  initial begin
    int   cyc;
    int   n;
    int   busy_seen;
    logic [7:0] ra, rb;
    bit   rs;

    nrst = 1'b0;
    req8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    req7 = 1'b0; sg7 = 1'b0; a7 = '0; b7 = '0;
    req16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", 64'(res8), 64'd0);
    chk("rst_done",   64'(done8), 64'd0);
    chk("rst_busy",   64'(busy8), 64'd0);
    nrst = 1'b1;

    // Most negative signed square
    do8(1'b1, 8'h80, 8'h80, cyc);
    chk("t1_latency", 64'(cyc), 64'd5);
    chk("t1_done",    64'(done8), 64'd1);
    chk("t1_result",  64'(res8), 64'h4000);

    do8(1'b0, 8'hFF, 8'hFF, cyc);
    chk("t2_unsigned", 64'(res8), 64'hFE01);
    do8(1'b1, 8'hFF, 8'hFF, cyc);
    chk("t2_signed", 64'(res8), 64'h0001);

    do8(1'b1, 8'hFF, 8'h7F, cyc);
    chk("t3_result", 64'(res8), 64'hFF81);
    @(negedge clk);
    req8 = 1'b1; sg8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
    @(negedge clk);
    req8 = 1'b0;
    chk("t3_done_low", 64'(done8), 64'd0);
    n = 0;
    while (busy8 && n < 20) begin
      chk("t3_hold", 64'(res8), 64'hFF81);
      n++;
      @(negedge clk);
    end
    chk("t3_next", 64'(res8), 64'd15);

    // Request mid-CALC must be ignored, not queued
    @(negedge clk);
    req8 = 1'b1; sg8 = 1'b0; a8 = 8'd12; b8 = 8'd13;
    @(negedge clk);
    req8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req8 = 1'b1; sg8 = 1'b1; a8 = 8'd100; b8 = 8'd100;
    @(negedge clk);
    req8 = 1'b0;
    n = 0;
    while (busy8 && n < 20) begin n++; @(negedge clk); end
    chk("t4_done",   64'(done8), 64'd1);
    chk("t4_result", 64'(res8), 64'd156);
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy8) busy_seen++;
    end
    chk("t4_no_restart", 64'(busy_seen), 64'd0);
    chk("t4_hold",       64'(res8), 64'd156);

    // Asynchronous reset during the third CALC step
    @(negedge clk);
    req8 = 1'b1; sg8 = 1'b1; a8 = 8'hFB; b8 = 8'h07;
    @(negedge clk);
    req8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t5_rst_result", 64'(res8), 64'd0);
    chk("t5_rst_done",   64'(done8), 64'd0);
    chk("t5_rst_busy",   64'(busy8), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    do8(1'b1, 8'hFB, 8'h07, cyc);
    chk("t5_latency", 64'(cyc), 64'd5);
    chk("t5_result",  64'(res8), 64'hFFDD);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      do8(rs, ra, rb, cyc);
      chk($sformatf("rand8_%0d", i), 64'(res8), 64'(refp(longint'(ra), longint'(rb), 8, rs)));
    end

    b2b(7);
    b2b(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
